// File: rtl/serial_pkg.sv
// ---------------------------------------------------------------------------
// serial_pkg
// Shared constants for the bit-serial adder: FSM state encoding and the
// default operand width.
// ---------------------------------------------------------------------------
package serial_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/full_adder.sv
// ---------------------------------------------------------------------------
// full_adder
// Single-bit full adder cell, purely combinational.
// Ports:
//   a, b  - operand bits
//   cin   - carry in
//   sum   - a ^ b ^ cin
//   cout  - majority(a, b, cin)
// ---------------------------------------------------------------------------
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
// Bit-serial WIDTH-bit adder. Operands are accepted through a valid/ready
// handshake, added LSB first at one bit per clock through a single
// full_adder cell, and the WIDTH-bit sum plus carry-out are presented
// through a valid/ready output handshake.
//
// Ports:
//   clk        - system clock, rising edge
//   rst_n      - asynchronous active-low reset
//   in_valid   - a, b, cin (and sub) are valid
//   in_ready   - block can accept operands (high in IDLE)
//   a, b       - WIDTH-bit operands
//   cin        - carry into bit 0
//   sub        - (SERIAL_ADDER_SUB_EN only) 1 = compute a - b
//   out_valid  - sum/cout are valid (high in DONE)
//   out_ready  - consumer accepts the result
//   sum, cout  - result; held from DONE until the next result
//   busy       - high in RUN or DONE
//
// Optional feature macro: SERIAL_ADDER_SUB_EN adds the sub input. When sub
// is high at acceptance, b is inverted and the carry forced to 1 (cin is
// ignored), so the result is a - b and cout=1 means no borrow.
// ---------------------------------------------------------------------------
module serial_adder
    import serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    // Only WIDTH-1 result bits need storing: the final bit goes straight
    // from the adder into sum on the RUN-to-DONE edge.
    logic [WIDTH-2:0] res_sh;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             fa_sum;
    logic             fa_cout;
    logic [WIDTH-1:0] b_load;
    logic             carry_load;

    // Operand conditioning at acceptance: subtraction is a + ~b + 1.
    // NOTE: every signal written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        b_load     = b;
        carry_load = cin;
`ifdef SERIAL_ADDER_SUB_EN
        if (sub) begin
            b_load     = ~b;
            carry_load = 1'b1;
        end
`endif
    end

    full_adder u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign busy      = (state == ST_RUN) || (state == ST_DONE);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_sh  <= a;
                        b_sh  <= b_load;
                        carry <= carry_load;
                        cnt   <= '0;
                        state <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= (WIDTH-1)'({fa_sum, res_sh} >> 1);
                    carry  <= fa_cout;
                    if (cnt == LAST_BIT) begin
                        // Counter is left at its last value so it never wraps.
                        sum   <= {fa_sum, res_sh};
                        cout  <= fa_cout;
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_serial_adder
// Self-checking bench for serial_adder (WIDTH=8). Expected results come from
// plain integer arithmetic on the operands. Build with SERIAL_ADDER_SUB_EN
// defined to include the subtraction vectors.
// ---------------------------------------------------------------------------
module tb_serial_adder;

    localparam int W = 8;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         in_ready;
    logic [W-1:0] a         = '0;
    logic [W-1:0] b         = '0;
    logic         cin       = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    logic         sub       = 1'b0;
`endif
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    int compared   = 0;
    int mismatched = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic         vcin;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: {cout,sum} = a + b + cin as plain integer addition.
    function automatic logic [W:0] add_model(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic c);
        int unsigned r;
        r = int'(x) + int'(y) + int'(c);
        return (W+1)'(r);
    endfunction

    // Called at a negedge with the DUT idle. Presents operands, waits for the
    // result, holds out_ready low for 'stall' DONE cycles, then accepts it.
    // Returns the captured result, the accept-to-out_valid latency and
    // whether sum/cout/out_valid stayed stable while stalled.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                          input int stall, output logic [W-1:0] rs, output logic rc,
                          output int lat, output bit stable);
        int guard;
        a = ta; b = tb_v; cin = tc;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a   = W'($urandom);
        b   = W'($urandom);
        cin = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        rs = sum;
        rc = cout;
        stable = 1'b1;
        if (out_valid) begin
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                if (sum !== rs || cout !== rc || !out_valid) stable = 1'b0;
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
    endtask

    initial begin
        vec_t         vecs[6];
        logic [W-1:0] rs;
        logic         rc;
        int           lat;
        bit           stable;
        logic [W:0]   exp;
        logic [W-1:0] ra, rb;
        logic         rci;
        logic [W-1:0] held_sum;
        logic         held_cout;
        int           guard;

        vecs[0] = '{8'd100, 8'd27,  1'b0, 8'd127, 1'b0};
        vecs[1] = '{8'hFF,  8'h01,  1'b0, 8'h00,  1'b1};
        vecs[2] = '{8'hFF,  8'hFF,  1'b1, 8'hFF,  1'b1};
        vecs[3] = '{8'h00,  8'h00,  1'b0, 8'h00,  1'b0};
        vecs[4] = '{8'h00,  8'h00,  1'b1, 8'h01,  1'b0};
        vecs[5] = '{8'h80,  8'h80,  1'b0, 8'h00,  1'b1};

        // Reset state
        repeat (2) @(negedge clk);
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset sum", 32'(sum), 32'd0);
        check("reset cout", 32'(cout), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors, out_ready effectively high on the first DONE cycle
        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].va, vecs[i].vb, vecs[i].vcin, 0, rs, rc, lat, stable);
            check($sformatf("vec%0d sum", i), 32'(rs), 32'(vecs[i].exp_sum));
            check($sformatf("vec%0d cout", i), 32'(rc), 32'(vecs[i].exp_cout));
            check($sformatf("vec%0d latency", i), 32'(lat), 32'(W));
            check($sformatf("vec%0d in_ready after", i), 32'(in_ready), 32'd1);
            check($sformatf("vec%0d busy after", i), 32'(busy), 32'd0);
        end

        // Backpressure in DONE with in_valid pulsing new operands
        a = 8'h5A; b = 8'h33; cin = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        guard = 0;
        while (!out_valid && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("stall latency", 32'(guard), 32'(W));
        held_sum  = sum;
        held_cout = cout;
        check("stall sum", 32'(held_sum), 32'h8E);
        check("stall cout", 32'(held_cout), 32'd0);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            a = W'($urandom);
            b = W'($urandom);
            @(negedge clk);
            check($sformatf("stall%0d sum held", i), 32'(sum), 32'(held_sum));
            check($sformatf("stall%0d cout held", i), 32'(cout), 32'(held_cout));
            check($sformatf("stall%0d in_ready", i), 32'(in_ready), 32'd0);
            check($sformatf("stall%0d out_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("stall%0d busy", i), 32'(busy), 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("post-stall in_ready", 32'(in_ready), 32'd1);
        check("post-stall out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("post-stall nothing queued", 32'(busy), 32'd0);

        // Asynchronous reset while cnt==3 in RUN
        a = 8'h11; b = 8'h22; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrun reset out_valid", 32'(out_valid), 32'd0);
        check("midrun reset busy", 32'(busy), 32'd0);
        check("midrun reset sum", 32'(sum), 32'd0);
        check("midrun reset cout", 32'(cout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("after reset in_ready", 32'(in_ready), 32'd1);
        run_op(8'h11, 8'h22, 1'b1, 1, rs, rc, lat, stable);
        check("after reset sum", 32'(rs), 32'h34);
        check("after reset cout", 32'(rc), 32'd0);
        check("after reset latency", 32'(lat), 32'(W));

        // Back-to-back random operations with random stalls
        for (int i = 0; i < 50; i++) begin
            ra  = W'($urandom);
            rb  = W'($urandom);
            rci = 1'($urandom);
            exp = add_model(ra, rb, rci);
            run_op(ra, rb, rci, int'($urandom_range(0, 3)), rs, rc, lat, stable);
            check($sformatf("rand%0d sum", i), 32'(rs), 32'(exp[W-1:0]));
            check($sformatf("rand%0d cout", i), 32'(rc), 32'(exp[W]));
            check($sformatf("rand%0d latency", i), 32'(lat), 32'(W));
            check($sformatf("rand%0d stable", i), 32'(stable), 32'd1);
        end

`ifdef SERIAL_ADDER_SUB_EN
        // Subtraction: cout=1 means a >= b (no borrow); cin is ignored
        sub = 1'b1;
        run_op(8'd10, 8'd3, 1'b0, 0, rs, rc, lat, stable);
        check("sub 10-3 sum", 32'(rs), 32'(W'(10 - 3)));
        check("sub 10-3 cout", 32'(rc), 32'd1);
        run_op(8'd3, 8'd10, 1'b1, 0, rs, rc, lat, stable);
        check("sub 3-10 sum", 32'(rs), 32'(W'(3 - 10)));
        check("sub 3-10 cout", 32'(rc), 32'd0);
        sub = 1'b0;
        run_op(8'd3, 8'd10, 1'b1, 0, rs, rc, lat, stable);
        check("add after sub sum", 32'(rs), 32'd14);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
